avmm_pio_bank: RTL and testbench



---
 rtl/pio_pkg.sv | 37 +++
 rtl/avmm_pio_bank_if.sv | 11 +
 rtl/pio_in_channel.sv | 87 ++++++++
 rtl/avmm_pio_bank.sv | 94 +++++++++
 tb/tb_avmm_pio_bank.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - address map constants, edge mode enum and address decode for the PIO bank
package pio_pkg;

    localparam int IN_BASE   = 16;
    localparam int IN_STRIDE = 4;

    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_EDGE = 2'd2;
    localparam logic [1:0] OFF_RSVD = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    typedef struct packed {
        logic       is_out;
        logic       is_in;
        logic [3:0] idx;
        logic [1:0] off;
    } addr_dec_t;

    // Input channels occupy 4-word windows starting at word 16, so addr[5:2]-4 is the channel.
    function automatic addr_dec_t decode_addr(input logic [5:0] addr, input int n_out, input int n_in);
        addr_dec_t  d;
        logic [3:0] ch;
        ch       = addr[5:2] - 4'(IN_BASE / IN_STRIDE);
        d.is_out = int'(addr) < n_out;
        d.is_in  = (addr[5:4] != 2'b00) && (int'(ch) < n_in);
        d.idx    = d.is_out ? addr[3:0] : ch;
        d.off    = addr[1:0];
        return d;
    endfunction

endpackage

// File: rtl/avmm_pio_bank_if.sv
// rtl/avmm_pio_bank_if.sv - Avalon-MM slave bus bundle for the PIO bank
interface avmm_pio_bank_if;
    logic [5:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_in_channel.sv
// rtl/pio_in_channel.sv - one input channel: synchroniser, vector debounce, edge capture, mask
module pio_in_channel
    import pio_pkg::*;
#(
    parameter int            DW           = 32,
    parameter int            DEBOUNCE_CYC = 50000,
    parameter edge_mode_e    EDGE_MODE    = EDGE_FALL,
    parameter logic [DW-1:0] IN_RESET     = '1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] pin,
    input  logic          mask_we,
    input  logic          edge_w1c,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] deb,
    output logic [DW-1:0] mask,
    output logic [DW-1:0] edge_bits,
    output logic          irq_term
);

    logic [DW-1:0] s1;
    logic [DW-1:0] sync;
    logic [DW-1:0] deb_prev;
    logic [DW-1:0] cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= IN_RESET;
            sync <= IN_RESET;
        end else begin
            s1   <= pin;
            sync <= s1;
        end
    end

    if (DEBOUNCE_CYC == 0) begin : g_bypass
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) deb <= IN_RESET;
            else          deb <= s1;
        end
    end else begin : g_filter
        localparam int            CW   = $clog2(DEBOUNCE_CYC + 1);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
        logic [CW-1:0] cnt;

        // s1 != sync means sync is changing on this edge, so the stable run restarts.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                deb <= IN_RESET;
            end else if (s1 != sync || sync == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cap = '0;
        case (EDGE_MODE)
            EDGE_RISE: cap = deb & ~deb_prev;
            EDGE_FALL: cap = ~deb & deb_prev;
            default:   cap = deb ^ deb_prev;
        endcase
    end

    // A capture landing with a clear of the same bit keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev  <= IN_RESET;
            mask      <= '0;
            edge_bits <= '0;
        end else begin
            deb_prev  <= deb;
            if (mask_we) mask <= wdata;
            edge_bits <= (edge_bits & ~(edge_w1c ? wdata : '0)) | cap;
        end
    end

    assign irq_term = |(edge_bits & mask);

endmodule

// File: rtl/avmm_pio_bank.sv
// rtl/avmm_pio_bank.sv - Avalon-MM PIO bank: output registers, input channels, read mux, irq
module avmm_pio_bank
    import pio_pkg::*;
#(
    parameter int            N_OUT        = 4,
    parameter int            N_IN         = 2,
    parameter int            DW           = 32,
    parameter int            DEBOUNCE_CYC = 50000,
    parameter int            EDGE_MODE    = 1,
    parameter logic [DW-1:0] IN_RESET     = '1,
    parameter logic [DW-1:0] OUT_RESET    = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    avmm_pio_bank_if.slave       bus,
    output logic                 irq,
    output logic [N_OUT*DW-1:0]  out_export,
    input  logic [N_IN*DW-1:0]   in_export
);

    addr_dec_t                   dec;
    logic [N_OUT-1:0][DW-1:0]    out_q;
    logic [N_IN-1:0][DW-1:0]     deb_a;
    logic [N_IN-1:0][DW-1:0]     mask_a;
    logic [N_IN-1:0][DW-1:0]     edge_a;
    logic [N_IN-1:0]             mask_we;
    logic [N_IN-1:0]             edge_w1c;
    logic [N_IN-1:0]             irq_terms;
    logic [31:0]                 rd_mux;

    assign dec        = decode_addr(bus.address, N_OUT, N_IN);
    assign out_export = out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= {N_OUT{OUT_RESET}};
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (bus.write && dec.is_out && int'(dec.idx) == k) out_q[k] <= bus.writedata[DW-1:0];
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign mask_we[i]  = bus.write && dec.is_in && int'(dec.idx) == i && dec.off == OFF_MASK;
        assign edge_w1c[i] = bus.write && dec.is_in && int'(dec.idx) == i && dec.off == OFF_EDGE;

        pio_in_channel #(
            .DW           (DW),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .EDGE_MODE    (edge_mode_e'(EDGE_MODE[1:0])),
            .IN_RESET     (IN_RESET)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .pin       (in_export[i*DW +: DW]),
            .mask_we   (mask_we[i]),
            .edge_w1c  (edge_w1c[i]),
            .wdata     (bus.writedata[DW-1:0]),
            .deb       (deb_a[i]),
            .mask      (mask_a[i]),
            .edge_bits (edge_a[i]),
            .irq_term  (irq_terms[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (dec.is_out && int'(dec.idx) == k) rd_mux[DW-1:0] = out_q[k];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (dec.is_in && int'(dec.idx) == i) begin
                case (dec.off)
                    OFF_DATA: rd_mux[DW-1:0] = deb_a[i];
                    OFF_MASK: rd_mux[DW-1:0] = mask_a[i];
                    OFF_EDGE: rd_mux[DW-1:0] = edge_a[i];
                    default:  rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (bus.read) bus.readdata <= rd_mux;
            irq <= |irq_terms;
        end
    end

endmodule

// File: tb/tb_avmm_pio_bank.sv
// tb/tb_avmm_pio_bank.sv - directed self-checking bench for avmm_pio_bank
module tb_avmm_pio_bank;

    logic        clk;
    logic        reset_n;
    logic        irq;
    logic [15:0] out_export;
    logic [15:0] in_export;
    int          checks;
    int          errors;

    avmm_pio_bank_if bus ();

    avmm_pio_bank #(
        .N_OUT        (2),
        .N_IN         (2),
        .DW           (8),
        .DEBOUNCE_CYC (4),
        .EDGE_MODE    (1),
        .IN_RESET     (8'hFF),
        .OUT_RESET    (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .irq        (irq),
        .out_export (out_export),
        .in_export  (in_export)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(posedge clk); #1;
        bus.write     = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        @(posedge clk); #1;
        bus.read    = 1'b0;
        d           = bus.readdata;
    endtask

    task automatic test_reset();
        logic [5:0]  addrs [12] = '{6'd0, 6'd1, 6'd3, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd63};
        logic [31:0] exps  [12] = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] d;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++;
        if (out_export !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out_export); end
        for (int i = 0; i < 12; i++) begin
            rd(addrs[i], d);
            checks++;
            if (d !== exps[i]) begin errors++; $display("FAIL reset_read addr %0d: got %h expected %h", addrs[i], d, exps[i]); end
        end
    endtask

    task automatic test_out_regs();
        logic [31:0] d;
        wr(6'd1, 32'h1234_56A5);
        checks++;
        if (out_export !== 16'hA500) begin errors++; $display("FAIL out1_export: got %h expected a500", out_export); end
        rd(6'd1, d);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL out1_read: got %h expected 000000a5", d); end
        wr(6'd0, 32'h0000_003C);
        checks++;
        if (out_export !== 16'hA53C) begin errors++; $display("FAIL out0_export: got %h expected a53c", out_export); end
        wr(6'd2, 32'h0000_0077);
        rd(6'd2, d);
        checks++;
        if (d !== 32'h0 || out_export !== 16'hA53C) begin errors++; $display("FAIL out_unmapped: got %h/%h expected 0/a53c", d, out_export); end
    endtask

    task automatic test_map_writes();
        logic [31:0] d;
        wr(6'd19, 32'hFF);
        rd(6'd19, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rsvd_write: got %h expected 0", d); end
        wr(6'd16, 32'h00);
        rd(6'd16, d);
        checks++;
        if (d !== 32'hFF) begin errors++; $display("FAIL data_readonly: got %h expected ff", d); end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        in_export[7:0] = 8'hFE;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            checks++;
            if (dut.g_in[0].u_ch.deb !== ((n >= 6) ? 8'hFE : 8'hFF)) begin
                errors++; $display("FAIL deb_timing cycle %0d: got %h expected %h", n, dut.g_in[0].u_ch.deb, (n >= 6) ? 8'hFE : 8'hFF);
            end
            checks++;
            if (dut.g_in[0].u_ch.edge_bits !== ((n >= 7) ? 8'h01 : 8'h00)) begin
                errors++; $display("FAIL edge_timing cycle %0d: got %h expected %h", n, dut.g_in[0].u_ch.edge_bits, (n >= 7) ? 8'h01 : 8'h00);
            end
        end
        rd(6'd16, d);
        checks++;
        if (d !== 32'hFE) begin errors++; $display("FAIL data0_read: got %h expected fe", d); end
        rd(6'd18, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL edge0_read: got %h expected 01", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    endtask

    task automatic test_irq();
        wr(6'd17, 32'h01);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked: got %b expected 1", irq); end
        wr(6'd18, 32'h01);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_w1c_lag: got %b expected 1", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        wr(6'd21, 32'h01);
        in_export[15:8] = 8'hFE;
        repeat (3) @(posedge clk);
        #1;
        in_export[15:8] = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        rd(6'd20, d);
        checks++;
        if (d !== 32'hFF) begin errors++; $display("FAIL glitch_data: got %h expected ff", d); end
        rd(6'd22, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL glitch_edge: got %h expected 00", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
    endtask

    task automatic test_capture_vs_w1c();
        logic [31:0] d;
        in_export[7:0] = 8'hFF;
        repeat (8) @(posedge clk);
        #1;
        rd(6'd16, d);
        checks++;
        if (d !== 32'hFF) begin errors++; $display("FAIL rise_data: got %h expected ff", d); end
        rd(6'd18, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL rise_not_captured: got %h expected 00", d); end
        in_export[7:0] = 8'hFE;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dut.g_in[0].u_ch.deb !== 8'hFE || dut.g_in[0].u_ch.edge_bits !== 8'h00) begin
            errors++; $display("FAIL pre_collide: got deb %h edge %h expected fe/00", dut.g_in[0].u_ch.deb, dut.g_in[0].u_ch.edge_bits);
        end
        wr(6'd18, 32'h01);
        checks++;
        if (dut.g_in[0].u_ch.edge_bits !== 8'h01) begin errors++; $display("FAIL collide_edge: got %h expected 01", dut.g_in[0].u_ch.edge_bits); end
        rd(6'd18, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL collide_read: got %h expected 01", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bus.address   = 6'd0;
        bus.writedata = 32'h5A;
        bus.write     = 1'b1;
        bus.read      = 1'b1;
        @(posedge clk); #1;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        checks++;
        if (bus.readdata !== 32'h3C) begin errors++; $display("FAIL rw_same_read: got %h expected 3c", bus.readdata); end
        checks++;
        if (out_export !== 16'hA55A) begin errors++; $display("FAIL rw_same_write: got %h expected a55a", out_export); end
        rd(6'd0, d);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL rw_readback: got %h expected 5a", d); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        in_export     = 16'hFFFF;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_out_regs();
        test_map_writes();
        test_debounce();
        test_irq();
        test_glitch();
        test_capture_vs_w1c();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
